// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state encodings
// and the iteration-counter width helper.
package seq_multiplier_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold 0..width-1; keep at least one bit for width=2.
    function automatic int cnt_bits(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Control FSM and iteration counter for seq_multiplier: issues load on accept,
// shift on every busy cycle, and flags the final iteration.
module seq_mul_ctrl
    import seq_multiplier_pkg::*;
#(
    parameter int width = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic ready,
    output logic busy,
    output logic done,
    output logic load,
    output logic shift,
    output logic last
);

    localparam int CW = cnt_bits(width);
    localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy  = (state_q == ST_BUSY);
    assign done  = (state_q == ST_DONE);
    assign load  = ready && start;
    assign shift = busy;
    assign last  = busy && (count_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    count_d = '0;
                end
            end
            ST_BUSY: begin
                // Counter parks at zero on exit so it never wraps past width-1.
                if (count_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = start ? ST_BUSY : ST_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one width+1-bit adder, width iterations per product.
// Optional signed mode (port sgn) is enabled by defining SEQ_MUL_SIGNED_EN.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int width = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] y
);

    logic load, shift, last;

    seq_mul_ctrl #(.width(width)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .load  (load),
        .shift (shift),
        .last  (last)
    );

    logic [width-1:0]   acc_q, acc_d;
    logic [width-1:0]   mcand_q, mcand_d;
    logic [width-1:0]   mplier_q, mplier_d;
    logic [2*width-1:0] y_q, y_d;
    logic [width:0]     sum;
    logic [2*width-1:0] prod;
    logic [width-1:0]   op_a, op_b;
    logic               neg_now;

`ifdef SEQ_MUL_SIGNED_EN
    logic neg_q, neg_d;

    // -2^(width-1) negates to itself, which is its correct unsigned magnitude.
    assign op_a    = (sgn && a[width-1]) ? -a : a;
    assign op_b    = (sgn && b[width-1]) ? -b : b;
    assign neg_d   = load ? (sgn && (a[width-1] ^ b[width-1])) : neg_q;
    assign neg_now = neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    assign op_a    = a;
    assign op_b    = b;
    assign neg_now = 1'b0;
`endif

    assign sum  = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign prod = {sum, mplier_q[width-1:1]};

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        y_d      = y_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
        end else if (shift) begin
            acc_d    = sum[width:1];
            mplier_d = {sum[0], mplier_q[width-1:1]};
            // y only moves on the edge that raises done.
            if (last) y_d = neg_now ? -prod : prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            y_q      <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            y_q      <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (width=4): directed cases, reset abort,
// ignored start while busy, and a full operand sweep; signed cases with SEQ_MUL_SIGNED_EN.
module tb_seq_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a, b;
    logic           sgn;
    logic           ready, busy, done;
    logic [2*W-1:0] y;

    always #5 clk = ~clk;

    seq_multiplier #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn   (sgn),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    typedef struct {
        logic [2*W-1:0] y;
        int             cyc;
        int             a;
        int             b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [2*W-1:0] model(input int ai, input int bi, input logic s);
        int sa, sb;
        sa = (s && ai >= (1 << (W-1))) ? ai - (1 << W) : ai;
        sb = (s && bi >= (1 << (W-1))) ? bi - (1 << W) : bi;
        return (2*W)'(sa * sb);
    endfunction

    // Monitor: pop and compare whenever the DUT raises done.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("txn a=%0h b=%0h y=%0h exp=%0h lat=%0d", e.a, e.b, y, e.y, cyc - e.cyc);
                check("product", {24'd0, y}, {24'd0, e.y});
                check("latency", cyc - e.cyc, W);
            end
        end
        prev_done <= rst_n && done;
    end

    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                         input logic [2*W-1:0] ey, input bit push);
        int k = 0;
        while (!ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
        start = 1'b1; a = ai; b = bi; sgn = si;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) exp_q.push_back('{y: ey, cyc: cyc, a: int'(ai), b: int'(bi)});
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_y",     {24'd0, y},     32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: max*max, result held afterwards
        issue(4'hF, 4'hF, 1'b0, 8'hE1, 1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("hold_y",     {24'd0, y},     32'hE1);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_busy",  {31'd0, busy},  32'd0);

        // 2: zero operand, then 1*1 back-to-back
        issue(4'h0, 4'h9, 1'b0, 8'h00, 1);
        issue(4'h1, 4'h1, 1'b0, 8'h01, 1);
        drain();

        // 3: start while busy is ignored
        dn = n_done;
        issue(4'h3, 4'h5, 1'b0, 8'h0F, 1);
        start = 1'b1; a = 4'h7; b = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("one_done_pulse", n_done - dn, 1);
        check("busy_start_y", {24'd0, y}, 32'h0F);

        // 4: async reset at iteration 2 aborts the operation
        issue(4'h5, 4'h5, 1'b0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_y",     {24'd0, y},     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'h6, 4'h7, 1'b0, 8'h2A, 1);
        drain();

`ifdef SEQ_MUL_SIGNED_EN
        // 5: signed mode
        issue(4'h8, 4'h8, 1'b1, 8'h40, 1);
        issue(4'hD, 4'h5, 1'b1, 8'hF1, 1);
        issue(4'h7, 4'hF, 1'b1, 8'hF9, 1);
        issue(4'hF, 4'hF, 1'b0, 8'hE1, 1);
        drain();
`endif

        // 6: full operand sweep, back-to-back
        for (int s = 0; s < 2; s++) begin
`ifndef SEQ_MUL_SIGNED_EN
            if (s == 1) break;
`endif
            for (int i = 0; i < (1 << W); i++) begin
                for (int j = 0; j < (1 << W); j++) begin
                    issue(W'(i), W'(j), s[0], model(i, j, s[0]), 1);
                end
            end
        end
        drain();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
